mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Sits directly upstream of the unified DataMem: the one memory array serves both instruction fetch (IF) and load/store (MEM).
// - Grants one requester per cycle and drives the memory port.
// - Registers the read result back to the winner and raises stall to the loser.
// - Detects misaligned/out-of-range data accesses and suppresses them.
// PARAMETERS
// - ADDR_W        6   memory word-address width (64 words)
// - DATA_RUN_MAX  4   consecutive data grants allowed while IF waits, before IF is forced in
// PORTS
// - clk         in   1        system clock; all state updates on posedge
// - rst         in   1        synchronous, active-high reset
// - if_req      in   1        fetch request
// - if_addr     in   32       fetch byte address
// - if_gnt      out  1        fetch granted this cycle (combinational)
// - if_valid    out  1        if_instr valid; registered, 1 cycle after if_gnt
// - if_instr    out  32       registered fetched word
// - d_read      in   1        load request
// - d_write     in   1        store request
// - d_addr      in   32       data byte address
// - d_wdata     in   32       store data
// - d_funct3    in   3        RISC-V load/store funct3
// - d_gnt       out  1        data granted this cycle
// - d_valid     out  1        d_rdata valid; registered, 1 cycle after a granted load
// - d_rdata     out  32       registered load result
// - d_err       out  1        registered, 1-cycle pulse: faulting access dropped
// - stall       out  1        requester pending but not granted this cycle
// - m_read      out  1        memory port: MemRead
// - m_write     out  1        memory port: MemWrite
// - m_addr      out  ADDR_W   memory port: word address
// - m_wdata     out  32       memory port: write data
// - m_funct3    out  3        memory port: function3
// - m_rdata     in   32       memory port: combinational read data
// BEHAVIOUR
// - Reset:
//   - if_valid, d_valid, d_err = 0; if_instr, d_rdata = 0; run counter = 0; FSM = S_IDLE.
//   - m_read and m_write are forced 0 while rst is high, so no write occurs during reset.
// - FSM (state = last granted requester):
//   - States: S_IDLE, S_FETCH, S_DATA.
//   - Next state is S_DATA when d_gnt, S_FETCH when if_gnt, S_IDLE when nothing is requested.
// - Arbitration, each cycle:
//   - Data request (d_read|d_write) wins by default.
//   - IF wins when run_cnt == DATA_RUN_MAX and if_req is high.
//   - run_cnt increments on each d_gnt while if_req is high.
//   - run_cnt clears on if_gnt or when !if_req; it saturates at DATA_RUN_MAX.
//   - Exactly one grant per cycle; d_read & d_write together is treated as a write.
// - Address mapping: m_addr = addr[ADDR_W+1:2]. Any addr[31:ADDR_W+2] != 0 is out of range.
// - Misalignment: LW/SW with addr[1:0] != 0; LH/LHU/SH with addr[0] != 0; byte ops never misalign.
// - Faulting data access:
//   - Still consumes its grant.
//   - m_read and m_write held 0 for that cycle.
//   - d_err pulses next cycle; d_valid stays 0.
// - Faulting fetch: if_valid = 1 with if_instr = 32'h00000013 (NOP).
// - Latency: the grant cycle drives the port; next posedge captures m_rdata into if_instr or d_rdata and pulses the valid.
// - Hold behaviour:
//   - if_instr and d_rdata hold their values until the next valid for the same requester.
//   - The valids are single-cycle pulses.
//   - Stores never set d_valid.
// - stall = (if_req & !if_gnt) | ((d_read|d_write) & !d_gnt).
//   - The pipeline freezes the loser; the loser must keep its request and address stable.
// - Reset mid-operation: a grant in the reset cycle is discarded; no valid or err pulse follows the reset.
// STRUCTURE
// - Shared in defines.v: F3_LB/LH/LW/LBU/LHU (000/001/010/100/101), F3_SB/SH/SW, NOP_INSTR,
//   and state encodings S_IDLE/S_FETCH/S_DATA.
// - One sub-module, mem_align_check (combinational): (addr, funct3, is_data) -> fault.
// TESTING
// - IF-only, if_addr=0x8 for 3 cycles -> m_addr=2 each cycle; if_valid pulses 1 cycle later with mem[2].
// - Simultaneous if_req and d_read at d_addr=0x24 -> d_gnt=1, stall=1; next cycle d_rdata=0x12345678, d_valid=1, IF granted.
// - Data requests for 5 consecutive cycles with if_req held (DATA_RUN_MAX=4) -> cycles 1-4 d_gnt; cycle 5 if_gnt; cycle 6 d_gnt.
// - SW d_addr=0x9E (misaligned) -> m_write stays 0, d_err pulses next cycle, mem[39] unchanged.
//   LW d_addr=0x100 (out of range) -> d_err pulses, d_valid stays 0.
// - LB d_addr=0xA8 -> d_rdata=0xFFFFFF80.
//   SW 0x11111111 @0x9C, then LW @0x9C -> d_rdata=0x11111111.
// - rst asserted during a granted SW -> no memory write; all valids and err stay 0; run_cnt=0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the unified memory port arbiter
package mem_port_arbiter_pkg;

    // Load and store funct3 codes share encodings; only the load names are used in decode.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DATA  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_align_check.sv
// rtl/mem_port_arbiter_align_check.sv - range and alignment fault detection for one access
module mem_align_check
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic [31:0] addr,
    input  logic [2:0]  funct3,
    input  logic        is_data,
    output logic        fault
);

    logic out_of_range;
    logic misaligned;

    assign out_of_range = (addr >> (ADDR_W + 2)) != 32'd0;

    // Fetches are always word accesses; unsupported data widths fault.
    always_comb begin
        misaligned = 1'b0;
        if (!is_data) begin
            misaligned = addr[1:0] != 2'b00;
        end else begin
            case (funct3)
                F3_LW:         misaligned = addr[1:0] != 2'b00;
                F3_LH, F3_LHU: misaligned = addr[0];
                F3_LB, F3_LBU: misaligned = 1'b0;
                default:       misaligned = 1'b1;
            endcase
        end
    end

    assign fault = out_of_range | misaligned;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter in front of a single unified memory array
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 6,
    parameter int DATA_RUN_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [2:0]        d_funct3,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              stall,
    output logic              m_read,
    output logic              m_write,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    output logic [2:0]        m_funct3,
    input  logic [31:0]       m_rdata
);

    localparam int RUN_W = $clog2(DATA_RUN_MAX + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [RUN_W-1:0] run_cnt;
    logic             d_req;
    logic             run_full;
    logic             if_fault;
    logic             d_fault;
    logic             sel_data;
    logic             d_load_ok;

    mem_align_check #(.ADDR_W(ADDR_W)) u_if_check (
        .addr    (if_addr),
        .funct3  (F3_LW),
        .is_data (1'b0),
        .fault   (if_fault)
    );

    mem_align_check #(.ADDR_W(ADDR_W)) u_d_check (
        .addr    (d_addr),
        .funct3  (d_funct3),
        .is_data (1'b1),
        .fault   (d_fault)
    );

    assign d_req    = d_read | d_write;
    assign run_full = run_cnt == RUN_W'(DATA_RUN_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (d_gnt) begin
            state_next = S_DATA;
        end else if (if_gnt) begin
            state_next = S_FETCH;
        end else begin
            state_next = S_IDLE;
        end
    end

    // An idle port keeps its mux on the last data winner to avoid needless address toggling.
    always_comb begin
        if_gnt   = if_req & (~d_req | run_full);
        d_gnt    = d_req & ~if_gnt;
        stall    = (if_req & ~if_gnt) | (d_req & ~d_gnt);
        sel_data = d_gnt | (~if_gnt & (state == S_DATA));
        m_addr   = sel_data ? d_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        m_funct3 = sel_data ? d_funct3 : F3_LW;
        m_wdata  = d_wdata;
        m_read   = ~rst & ((if_gnt & ~if_fault) | (d_gnt & ~d_write & ~d_fault));
        m_write  = ~rst & d_gnt & d_write & ~d_fault;
    end

    assign d_load_ok = d_gnt & ~d_write & ~d_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            d_err    <= 1'b0;
            if_instr <= 32'd0;
            d_rdata  <= 32'd0;
            run_cnt  <= '0;
        end else begin
            if_valid <= if_gnt;
            d_valid  <= d_load_ok;
            d_err    <= d_gnt & d_fault;
            if (if_gnt) begin
                if_instr <= if_fault ? NOP_INSTR : m_rdata;
            end
            if (d_load_ok) begin
                d_rdata <= m_rdata;
            end
            if (if_gnt | ~if_req) begin
                run_cnt <= '0;
            end else if (d_gnt & ~run_full) begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule
